alu_ctrl_md: RTL and testbench

Parametrised successor to the ALU decoder for the multicycle MIPS core. Maps `alu_op`/`funct` to an extended ALU control code, and adds an iterative multiply/divide engine with HI/LO registers and a busy/done handshake. The main control FSM uses this handshake as a stall source. The block sits between the control FSM and the datapath ALU/register-file write mux.

---
 rtl/alu_pkg.sv | 62 ++++++
 rtl/alu_ctrl_md_mult_div_core.sv | 126 ++++++++++++
 rtl/alu_ctrl_md.sv | 96 +++++++++
 tb/tb_alu_ctrl_md.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU decoder and the multiply/divide engine:
// ALU control codes, funct field values, alu_op / md-op / FSM state enums.
package alu_pkg;

    localparam int unsigned ALU_CODE_W = 4;
    localparam int unsigned FUNCT_W    = 6;

    // ALU control codes
    localparam logic [ALU_CODE_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [ALU_CODE_W-1:0] ALU_NOR  = 4'b0100;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 4'b1000;

    // R-type funct values
    localparam logic [FUNCT_W-1:0] F_ADD   = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_ADDU  = 6'b100001;
    localparam logic [FUNCT_W-1:0] F_SUB   = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_SUBU  = 6'b100011;
    localparam logic [FUNCT_W-1:0] F_AND   = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR    = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_XOR   = 6'b100110;
    localparam logic [FUNCT_W-1:0] F_NOR   = 6'b100111;
    localparam logic [FUNCT_W-1:0] F_SLT   = 6'b101010;
    localparam logic [FUNCT_W-1:0] F_SLTU  = 6'b101011;
    localparam logic [FUNCT_W-1:0] F_MFHI  = 6'b010000;
    localparam logic [FUNCT_W-1:0] F_MFLO  = 6'b010010;
    localparam logic [FUNCT_W-1:0] F_MULT  = 6'b011000;
    localparam logic [FUNCT_W-1:0] F_MULTU = 6'b011001;
    localparam logic [FUNCT_W-1:0] F_DIV   = 6'b011010;
    localparam logic [FUNCT_W-1:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_AND   = 2'b11
    } alu_op_e;

    // Encoding matches funct[1:0] of the mult/multu/div/divu group
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } md_state_e;

    // mult, multu, div, divu share funct prefix 0110xx
    function automatic logic is_md_funct(input logic [FUNCT_W-1:0] f);
        return f[5:2] == 4'b0110;
    endfunction

endpackage

// File: rtl/alu_ctrl_md_mult_div_core.sv
// Iterative multiply/divide datapath: one shift-add or restoring
// shift-subtract step per cycle for WIDTH cycles, then one sign-fix cycle.
// Ports: clk, rst_n, start_core (accept strobe, honoured only when idle),
// op (md_op_e encoding), a/b operands, busy (registered, RUN or FIX),
// done_core (high during the FIX cycle), res_hi_c/res_lo_c (final HI/LO,
// valid while done_core is high).
module mult_div_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_core,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done_core,
    output logic [WIDTH-1:0] res_hi_c,
    output logic [WIDTH-1:0] res_lo_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    md_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] p_hi;     // product high half / partial remainder
    logic [WIDTH-1:0] p_lo;     // multiplier / dividend shifting into quotient
    logic [WIDTH-1:0] dvs;      // multiplicand or divisor magnitude
    logic             is_div;
    logic             div0;
    logic             neg_q;    // product or quotient needs negation
    logic             neg_r;    // remainder needs negation

    md_op_e           op_e;
    logic             signed_op;
    logic             neg_a_c;
    logic             neg_b_c;
    logic [WIDTH-1:0] mag_a_c;
    logic [WIDTH-1:0] mag_b_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_trial_c;
    logic [2*WIDTH-1:0] prod_c;

    // Operand magnitudes, single iteration step and final sign fix
    always_comb begin
        op_e        = md_op_e'(op);
        signed_op   = (op_e == MD_MULT) || (op_e == MD_DIV);
        neg_a_c     = signed_op & a[WIDTH-1];
        neg_b_c     = signed_op & b[WIDTH-1];
        mag_a_c     = neg_a_c ? (-a) : a;
        mag_b_c     = neg_b_c ? (-b) : b;
        mul_sum_c   = {1'b0, p_hi} + (p_lo[0] ? {1'b0, dvs} : '0);
        div_trial_c = {p_hi, p_lo[WIDTH-1]} - {1'b0, dvs};
        prod_c      = neg_q ? (-{p_hi, p_lo}) : {p_hi, p_lo};
        res_hi_c    = prod_c[2*WIDTH-1:WIDTH];
        res_lo_c    = prod_c[WIDTH-1:0];
        if (is_div) begin
            // Divide-by-zero leaves |a| in the remainder; re-signing it restores a
            res_hi_c = neg_r ? (-p_hi) : p_hi;
            res_lo_c = div0 ? '1 : (neg_q ? (-p_lo) : p_lo);
        end
        done_core = (state == ST_FIX);
    end

    // Engine FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            cnt    <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            dvs    <= '0;
            is_div <= 1'b0;
            div0   <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_core) begin
                        state  <= ST_RUN;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        p_hi   <= '0;
                        p_lo   <= mag_a_c;
                        dvs    <= mag_b_c;
                        is_div <= op[1];
                        div0   <= op[1] && (b == '0);
                        neg_q  <= neg_a_c ^ neg_b_c;
                        neg_r  <= neg_a_c;
                    end
                end
                ST_RUN: begin
                    if (is_div) begin
                        if (!div_trial_c[WIDTH]) begin
                            p_hi <= div_trial_c[WIDTH-1:0];
                            p_lo <= {p_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            p_hi <= {p_hi[WIDTH-2:0], p_lo[WIDTH-1]};
                            p_lo <= {p_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        p_hi <= mul_sum_c[WIDTH:1];
                        p_lo <= {mul_sum_c[0], p_lo[WIDTH-1:1]};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_ctrl_md.sv
// ALU control decoder with an attached iterative multiply/divide engine.
// Ports: clk, rst_n; alu_op/funct decode into alu_control, illegal_funct and
// hilo_sel (combinational); start with a mult/multu/div/divu funct launches
// the engine when idle; md_busy (stall source), md_done (one-cycle pulse
// when HI/LO update), hi/lo register contents.
module alu_ctrl_md
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic [CTRL_W-1:0] alu_control,
    output logic              illegal_funct,
    output logic [1:0]        hilo_sel,
    output logic              md_busy,
    output logic              md_done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    logic             accept_c;
    logic             done_core;
    logic [WIDTH-1:0] res_hi_c;
    logic [WIDTH-1:0] res_lo_c;

    // alu_op / funct decode
    always_comb begin
        alu_control   = CTRL_W'(ALU_AND);
        illegal_funct = 1'b0;
        hilo_sel      = 2'b00;
        case (alu_op_e'(alu_op))
            ALUOP_ADD: alu_control = CTRL_W'(ALU_ADD);
            ALUOP_SUB: alu_control = CTRL_W'(ALU_SUB);
            ALUOP_AND: alu_control = CTRL_W'(ALU_AND);
            ALUOP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: alu_control = CTRL_W'(ALU_ADD);
                    F_SUB, F_SUBU: alu_control = CTRL_W'(ALU_SUB);
                    F_AND:         alu_control = CTRL_W'(ALU_AND);
                    F_OR:          alu_control = CTRL_W'(ALU_OR);
                    F_XOR:         alu_control = CTRL_W'(ALU_XOR);
                    F_NOR:         alu_control = CTRL_W'(ALU_NOR);
                    F_SLT:         alu_control = CTRL_W'(ALU_SLT);
                    F_SLTU:        alu_control = CTRL_W'(ALU_SLTU);
                    F_MFHI:        hilo_sel    = 2'b01;
                    F_MFLO:        hilo_sel    = 2'b10;
                    F_MULT, F_MULTU, F_DIV, F_DIVU: alu_control = CTRL_W'(ALU_AND);
                    default:       illegal_funct = 1'b1;
                endcase
            end
            default: alu_control = CTRL_W'(ALU_AND);
        endcase
    end

    // Launch only on an R-type mult/div while the engine is idle
    assign accept_c = start && (alu_op_e'(alu_op) == ALUOP_RTYPE)
                      && is_md_funct(funct) && !md_busy;

    mult_div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_core (accept_c),
        .op         (funct[1:0]),
        .a          (a),
        .b          (b),
        .busy       (md_busy),
        .done_core  (done_core),
        .res_hi_c   (res_hi_c),
        .res_lo_c   (res_lo_c)
    );

    // HI/LO written on the edge leaving FIX; md_done marks the following cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi      <= '0;
            lo      <= '0;
            md_done <= 1'b0;
        end else begin
            md_done <= done_core;
            if (done_core) begin
                hi <= res_hi_c;
                lo <= res_lo_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed bench for alu_ctrl_md: decode vectors, multiply/divide results,
// handshake timing, busy/back-to-back starts and mid-operation reset.
module tb_alu_ctrl_md;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_control;
    logic        illegal_funct;
    logic [1:0]  hilo_sel;
    logic        md_busy;
    logic        md_done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;
    int lat;
    int busy_n;
    int done_seen;

    alu_ctrl_md #(.WIDTH(32), .CTRL_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_op        (alu_op),
        .funct         (funct),
        .start         (start),
        .a             (a),
        .b             (b),
        .alu_control   (alu_control),
        .illegal_funct (illegal_funct),
        .hilo_sel      (hilo_sel),
        .md_busy       (md_busy),
        .md_done       (md_done),
        .hi            (hi),
        .lo            (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op; returns cycles from accept edge to md_done and busy-cycle count.
    // At cycle inject_at a second mult start is driven while the engine runs.
    task automatic run_op(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                          input int inject_at, output int lat_o, output int busy_o);
        alu_op = 2'b10;
        funct  = f;
        a      = av;
        b      = bv;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        lat_o  = 0;
        busy_o = md_busy ? 1 : 0;
        while (lat_o < 40) begin
            if (lat_o == inject_at) begin
                funct = F_MULT;
                a     = 32'd100;
                b     = 32'd100;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat_o++;
            if (md_done) break;
            if (md_busy) busy_o++;
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        alu_op = 2'b00;
        funct  = 6'b000000;
        a      = '0;
        b      = '0;
        #12;
        chk("rst_busy", 64'(md_busy), 64'd0);
        chk("rst_done", 64'(md_done), 64'd0);
        chk("rst_hi",   64'(hi), 64'd0);
        chk("rst_lo",   64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Decode
        alu_op = 2'b10; funct = F_SUB; #1;
        chk("dec_sub", 64'(alu_control), 64'h6);
        funct = F_SLTU; #1;
        chk("dec_sltu", 64'(alu_control), 64'h8);
        chk("dec_sltu_legal", 64'(illegal_funct), 64'd0);
        funct = 6'b111111; #1;
        chk("dec_bad_ctrl", 64'(alu_control), 64'h0);
        chk("dec_bad_ill", 64'(illegal_funct), 64'd1);
        funct = F_OR; #1;
        chk("dec_or", 64'(alu_control), 64'h1);
        funct = F_MFHI; #1;
        chk("dec_mfhi", 64'(hilo_sel), 64'h1);
        funct = F_MFLO; #1;
        chk("dec_mflo", 64'(hilo_sel), 64'h2);
        funct = F_DIVU; #1;
        chk("dec_divu_ctrl", 64'(alu_control), 64'h0);
        chk("dec_divu_ill", 64'(illegal_funct), 64'd0);
        alu_op = 2'b01; funct = 6'b111111; #1;
        chk("dec_op01", 64'(alu_control), 64'h6);
        chk("dec_op01_ill", 64'(illegal_funct), 64'd0);
        alu_op = 2'b00; #1;
        chk("dec_op00", 64'(alu_control), 64'h2);
        alu_op = 2'b11; #1;
        chk("dec_op11", 64'(alu_control), 64'h0);

        // Starts that must be ignored
        alu_op = 2'b00; funct = F_MULT; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_aluop", 64'(md_busy), 64'd0);
        alu_op = 2'b10; funct = F_ADD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ign_funct", 64'(md_busy), 64'd0);

        // multu max x max with handshake timing
        run_op(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, lat, busy_n);
        chk("multu_lat", 64'(lat), 64'd33);
        chk("multu_busy_cycles", 64'(busy_n), 64'd33);
        chk("multu_busy_at_done", 64'(md_busy), 64'd0);
        chk("multu_hi", 64'(hi), 64'hFFFFFFFE);
        chk("multu_lo", 64'(lo), 64'h00000001);
        @(posedge clk); #1;
        chk("multu_done_width", 64'(md_done), 64'd0);

        run_op(F_MULT, 32'hFFFFFFFD, 32'd5, -1, lat, busy_n);
        chk("mult_neg_lat", 64'(lat), 64'd33);
        chk("mult_neg_hi", 64'(hi), 64'hFFFFFFFF);
        chk("mult_neg_lo", 64'(lo), 64'hFFFFFFF1);
        @(posedge clk); #1;

        run_op(F_MULT, 32'h80000000, 32'h80000000, -1, lat, busy_n);
        chk("mult_min_hi", 64'(hi), 64'h40000000);
        chk("mult_min_lo", 64'(lo), 64'h00000000);
        @(posedge clk); #1;

        run_op(F_DIV, 32'hFFFFFFF9, 32'd2, -1, lat, busy_n);
        chk("div_neg_lat", 64'(lat), 64'd33);
        chk("div_neg_lo", 64'(lo), 64'hFFFFFFFD);
        chk("div_neg_hi", 64'(hi), 64'hFFFFFFFF);
        @(posedge clk); #1;

        run_op(F_DIVU, 32'd7, 32'd0, -1, lat, busy_n);
        chk("divu0_lat", 64'(lat), 64'd33);
        chk("divu0_lo", 64'(lo), 64'hFFFFFFFF);
        chk("divu0_hi", 64'(hi), 64'h00000007);
        @(posedge clk); #1;

        run_op(F_DIV, 32'hFFFFFFFB, 32'd0, -1, lat, busy_n);
        chk("div0_neg_lo", 64'(lo), 64'hFFFFFFFF);
        chk("div0_neg_hi", 64'(hi), 64'hFFFFFFFB);
        @(posedge clk); #1;

        run_op(F_DIV, 32'h80000000, 32'hFFFFFFFF, -1, lat, busy_n);
        chk("div_ovf_lo", 64'(lo), 64'h80000000);
        chk("div_ovf_hi", 64'(hi), 64'h00000000);
        @(posedge clk); #1;

        // Start while busy is ignored
        run_op(F_MULT, 32'd2, 32'd3, 5, lat, busy_n);
        chk("busy_ign_lat", 64'(lat), 64'd33);
        chk("busy_ign_lo", 64'(lo), 64'd6);
        chk("busy_ign_hi", 64'(hi), 64'd0);
        @(posedge clk); #1;
        chk("busy_ign_idle", 64'(md_busy), 64'd0);

        // Back-to-back: second start lands in the md_done cycle
        run_op(F_MULTU, 32'd9, 32'd9, -1, lat, busy_n);
        chk("b2b_first_lo", 64'(lo), 64'd81);
        run_op(F_DIVU, 32'd100, 32'd7, -1, lat, busy_n);
        chk("b2b_second_lat", 64'(lat), 64'd33);
        chk("b2b_second_lo", 64'(lo), 64'd14);
        chk("b2b_second_hi", 64'(hi), 64'd2);
        @(posedge clk); #1;

        // Reset mid-RUN aborts without writing HI/LO
        alu_op = 2'b10; funct = F_MULT; a = 32'h1234; b = 32'h5678; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(md_busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        #2;
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (md_done) done_seen = 1;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);

        run_op(F_MULT, 32'd6, 32'd7, -1, lat, busy_n);
        chk("post_abort_lat", 64'(lat), 64'd33);
        chk("post_abort_lo", 64'(lo), 64'd42);
        chk("post_abort_hi", 64'(hi), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
